md5_search_driver: RTL and testbench

//   Brute-force initiator for the md5 hash core: generates candidate messages over [a-z],

---
 rtl/md5_pkg.sv | 19 +
 rtl/md5_cand_odometer.sv | 67 ++++++
 rtl/md5_search_driver.sv | 156 +++++++++++++++
 tb/tb_md5_search_driver.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_pkg.sv
// Shared constants and state encoding for the md5 brute-force search driver.
package md5_pkg;

  localparam logic [7:0]  CHAR_BASE    = 8'h61;
  localparam int unsigned CHARSET_SIZE = 26;
  localparam int unsigned IDX_W        = 5;
  localparam int unsigned HASH_W       = 128;
  localparam int unsigned LEN_W        = 5;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StCheck,
    StNext,
    StDone
  } state_e;

endpackage

// File: rtl/md5_cand_odometer.sv
// Candidate odometer: base-26 digits over [a-z], shortest length first, last char fastest.
module md5_cand_odometer
  import md5_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              init_i,
  input  logic              inc_i,
  output logic [0:HASH_W-1] msg_o,
  output logic [0:7]        width_o,
  output logic              last_o
);

  logic [IDX_W-1:0] idx_q   [MAX_LEN];
  logic [IDX_W-1:0] idx_d   [MAX_LEN];
  logic [IDX_W-1:0] idx_inc [MAX_LEN];
  logic [LEN_W-1:0] len_q, len_d;
  logic             carry;

  always_comb begin
    idx_inc = idx_q;
    carry   = 1'b1;
    // Ripple from the last active position towards position 0.
    for (int i = int'(MAX_LEN) - 1; i >= 0; i--) begin
      if (carry && (i < int'(len_q))) begin
        if (idx_q[i] == IDX_W'(CHARSET_SIZE - 1)) begin
          idx_inc[i] = '0;
        end else begin
          idx_inc[i] = idx_q[i] + 1'b1;
          carry      = 1'b0;
        end
      end
    end
    last_o = carry && (len_q == LEN_W'(MAX_LEN));

    idx_d = idx_q;
    len_d = len_q;
    if (init_i) begin
      for (int i = 0; i < int'(MAX_LEN); i++) idx_d[i] = '0;
      len_d = LEN_W'(1);
    end else if (inc_i && !last_o) begin
      idx_d = idx_inc;
      if (carry) len_d = len_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(MAX_LEN); i++) idx_q[i] <= '0;
      len_q <= LEN_W'(1);
    end else begin
      idx_q <= idx_d;
      len_q <= len_d;
    end
  end

  always_comb begin
    msg_o = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if (i < int'(len_q)) msg_o[8*i +: 8] = CHAR_BASE + 8'(idx_q[i]);
    end
    width_o = {len_q, 3'b000};
  end

endmodule

// File: rtl/md5_search_driver.sv
// Brute-force search driver: walks the candidate odometer through one md5 core and
// compares each returned hash against a captured target.
module md5_search_driver
  import md5_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [0:127]      target_hash,
  output logic [0:127]      msg_in,
  output logic [0:7]        msg_in_width,
  output logic              msg_in_valid,
  input  logic              core_ready,
  input  logic [0:127]      core_hash,
  input  logic              core_hash_valid,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic              err,
  output logic [0:127]      found_msg,
  output logic [CNT_W-1:0]  cand_count
);

  localparam int unsigned TW = $clog2(TIMEOUT);

  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [0:HASH_W-1] hash_q, hash_d;
  logic [0:HASH_W-1] target_q, target_d;
  logic [0:HASH_W-1] found_msg_q, found_msg_d;
  logic              found_q, found_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              odo_init, odo_inc, odo_last;
  logic [0:HASH_W-1] cand_msg;
  logic [0:7]        cand_width;

  md5_cand_odometer #(
    .MAX_LEN (MAX_LEN)
  ) u_odometer (
    .clk     (clk),
    .reset_n (reset_n),
    .init_i  (odo_init),
    .inc_i   (odo_inc),
    .msg_o   (cand_msg),
    .width_o (cand_width),
    .last_o  (odo_last)
  );

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    hash_d       = hash_q;
    target_d     = target_q;
    found_msg_d  = found_msg_q;
    found_d      = found_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    odo_init     = 1'b0;
    odo_inc      = 1'b0;
    msg_in_valid = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          odo_init    = 1'b1;
          target_d    = target_hash;
          found_d     = 1'b0;
          err_d       = 1'b0;
          found_msg_d = '0;
          cnt_d       = '0;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        // One-shot request: leaving ISSUE on the same edge rules out a double issue.
        if (core_ready) begin
          msg_in_valid = 1'b1;
          cnt_d        = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          timer_d      = '0;
          state_d      = StWait;
        end
      end
      StWait: begin
        if (core_hash_valid) begin
          hash_d  = core_hash;
          state_d = StCheck;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StCheck: begin
        if (hash_q == target_q) begin
          found_d     = 1'b1;
          found_msg_d = cand_msg;
          state_d     = StDone;
        end else begin
          state_d = StNext;
        end
      end
      StNext: begin
        if (odo_last) begin
          state_d = StDone;
        end else begin
          odo_inc = 1'b1;
          state_d = StIssue;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      hash_q      <= '0;
      target_q    <= '0;
      found_msg_q <= '0;
      found_q     <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      hash_q      <= hash_d;
      target_q    <= target_d;
      found_msg_q <= found_msg_d;
      found_q     <= found_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  // The odometer comes out of reset holding "a"; keep the core-facing bus quiet until a search.
  always_comb begin
    msg_in       = (state_q == StIdle) ? '0 : cand_msg;
    msg_in_width = (state_q == StIdle) ? '0 : cand_width;
    busy         = (state_q == StIssue) || (state_q == StWait) ||
                   (state_q == StCheck) || (state_q == StNext);
    done         = (state_q == StDone);
    found        = found_q;
    err          = err_q;
    found_msg    = found_msg_q;
    cand_count   = cnt_q;
  end

endmodule

// File: tb/tb_md5_search_driver.sv
// Bench for md5_search_driver: behavioural md5 core, reference search model, result scoreboard.
module tb_md5_search_driver;

  localparam int MAX_LEN = 2;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 32;
  localparam int NCAND   = 26 + 26 * 26;
  localparam int BUDGET  = 40000;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic [0:127]     target_hash;
  logic [0:127]     msg_in;
  logic [0:7]       msg_in_width;
  logic             msg_in_valid;
  logic             core_ready;
  logic [0:127]     core_hash;
  logic             core_hash_valid;
  logic             busy;
  logic             done;
  logic             found;
  logic             err;
  logic [0:127]     found_msg;
  logic [CNT_W-1:0] cand_count;

  md5_search_driver #(
    .MAX_LEN (MAX_LEN),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .target_hash     (target_hash),
    .msg_in          (msg_in),
    .msg_in_width    (msg_in_width),
    .msg_in_valid    (msg_in_valid),
    .core_ready      (core_ready),
    .core_hash       (core_hash),
    .core_hash_valid (core_hash_valid),
    .busy            (busy),
    .done            (done),
    .found           (found),
    .err             (err),
    .found_msg       (found_msg),
    .cand_count      (cand_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           found;
    bit           err;
    bit           tmo;
    logic [0:127] msg;
    int           width;
    int           count;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 16;
  bit          drop_mode = 0;
  bit          ready_low = 0;
  int          issue_n = 0;
  int          issue_cyc = 0;
  logic [31:0] k_tab [64];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  // Single-block md5 of the first len bytes of msg (byte i at msg[8*i +: 8]).
  function automatic logic [0:127] md5_of(input logic [0:127] msg, input int len);
    logic [7:0]   blk [64];
    logic [31:0]  m [16];
    logic [31:0]  a, b, c, d, f, w;
    logic [0:127] res;
    int           g, s;
    int           sh [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
    for (int i = 0; i < 64; i++) blk[i] = 8'h00;
    for (int i = 0; i < len; i++) blk[i] = msg[8*i +: 8];
    blk[len] = 8'h80;
    blk[56]  = 8'(len * 8);
    for (int j = 0; j < 16; j++) m[j] = {blk[4*j+3], blk[4*j+2], blk[4*j+1], blk[4*j]};
    a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
    for (int i = 0; i < 64; i++) begin
      if (i < 16)      begin f = (b & c) | (~b & d); g = i;                end
      else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
      else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
      else             begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
      f = f + a + k_tab[i] + m[g];
      a = d; d = c; c = b;
      s = sh[(i / 16) * 4 + (i % 4)];
      b = b + ((f << s) | (f >> (32 - s)));
    end
    a = a + 32'h67452301; b = b + 32'hefcdab89; c = c + 32'h98badcfe; d = d + 32'h10325476;
    for (int bb = 0; bb < 4; bb++) begin
      res[8*bb +: 8]      = a[8*bb +: 8];
      res[8*(4+bb) +: 8]  = b[8*bb +: 8];
      res[8*(8+bb) +: 8]  = c[8*bb +: 8];
      res[8*(12+bb) +: 8] = d[8*bb +: 8];
    end
    return res;
  endfunction

  // n-th candidate (0-based) in shortest-first, base-26 order.
  function automatic void cand_of(input int n, output logic [0:127] m, output int l);
    int p = 26;
    int r = n;
    l = 1;
    while (r >= p) begin
      r -= p;
      l++;
      p *= 26;
    end
    m = '0;
    for (int i = l - 1; i >= 0; i--) begin
      m[8*i +: 8] = 8'h61 + 8'(r % 26);
      r = r / 26;
    end
  endfunction

  function automatic exp_t model_search(input logic [0:127] target);
    exp_t         e;
    logic [0:127] m;
    int           l;
    e = '{found: 0, err: 0, tmo: 0, msg: '0, width: 0, count: NCAND};
    for (int n = 0; n < NCAND; n++) begin
      cand_of(n, m, l);
      if (md5_of(m, l) == target) begin
        e.found = 1; e.msg = m; e.width = 8 * l; e.count = n + 1;
        return e;
      end
    end
    return e;
  endfunction

  // Behavioural md5 core with configurable latency; also checks each request.
  initial begin
    logic [0:127] h, em;
    int           cnt, el;
    bit           pending, prev_valid;
    pending = 0; prev_valid = 0; cnt = 0; h = '0;
    core_ready = 1'b0; core_hash = '0; core_hash_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pending = 0; prev_valid = 0; core_hash_valid = 1'b0; core_ready = 1'b0;
        continue;
      end
      core_hash_valid = 1'b0;
      if (pending) begin
        if (cnt == 0) begin
          core_hash = h; core_hash_valid = 1'b1; pending = 0;
        end else begin
          cnt--;
        end
      end
      core_ready = !ready_low && ($urandom_range(3) != 0);
      #1;
      if (msg_in_valid) begin
        chk("issue_one_cycle", 128'(prev_valid), 128'(0));
        chk("issue_before_hash", 128'(pending), 128'(0));
        chk("issue_needs_ready", 128'(core_ready), 128'(1));
        cand_of(issue_n, em, el);
        chk("issue_msg", msg_in, em);
        chk("issue_width", 128'(msg_in_width), 128'(8 * el));
        issue_n++;
        issue_cyc = cyc;
        if (!drop_mode) begin
          h = md5_of(msg_in, int'(msg_in_width) / 8);
          pending = 1;
          cnt = lat - 1;
        end
      end
      prev_valid = msg_in_valid;
    end
  end

  // Scoreboard monitor: pops one expected result per completed search.
  initial begin
    exp_t e;
    bit   done_prev = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset_n) begin
        done_prev = 0;
        continue;
      end
      if (done && !done_prev) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_done", 128'(1), 128'(0));
        end else begin
          e = sb_q.pop_front();
          chk("res_found", 128'(found), 128'(e.found));
          chk("res_err", 128'(err), 128'(e.err));
          chk("res_found_msg", found_msg, e.msg);
          chk("res_cand_count", 128'(cand_count), 128'(e.count));
          chk("res_busy_low", 128'(busy), 128'(0));
          if (e.found) chk("res_width", 128'(msg_in_width), 128'(e.width));
          if (e.tmo) chk("res_timeout_cycles", 128'(cyc - issue_cyc), 128'(TIMEOUT + 1));
        end
      end
      done_prev = done;
    end
  end

  task automatic launch(input logic [0:127] target, input exp_t e);
    @(negedge clk);
    target_hash = target;
    start = 1'b1;
    issue_n = 0;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_within_budget", 128'(0), 128'(1));
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 128'(msg_in_valid), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
    chk({tag, "_found"}, 128'(found), 128'(0));
    chk({tag, "_err"}, 128'(err), 128'(0));
    chk({tag, "_msg"}, msg_in, 128'(0));
    chk({tag, "_width"}, 128'(msg_in_width), 128'(0));
    chk({tag, "_found_msg"}, found_msg, 128'(0));
    chk({tag, "_count"}, 128'(cand_count), 128'(0));
  endtask

  initial begin
    exp_t         e_a, e_ab, e;
    logic [0:127] t_a, t_ab, t, m;
    int           l;
    real          r;
    longint       v;

    for (int i = 0; i < 64; i++) begin
      r = $sin(real'(i + 1));
      if (r < 0.0) r = -r;
      v = longint'($floor(r * 4294967296.0));
      k_tab[i] = v[31:0];
    end

    reset_n = 1'b0; start = 1'b0; target_hash = '0;
    repeat (3) @(negedge clk);
    #2 check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    t_a  = 128'h0cc175b9c0f1b6a831c399e269772661;
    t_ab = 128'h187ef4436122d1cc2f40dc2b92f0eba0;
    m = '0; m[0:7] = 8'h61;
    e_a = '{found: 1, err: 0, tmo: 0, msg: m, width: 8, count: 1};
    m[8:15] = 8'h62;
    e_ab = '{found: 1, err: 0, tmo: 0, msg: m, width: 16, count: 28};

    // "a" at default latency.
    lat = 16;
    launch(t_a, e_a);
    wait_done();

    // "ab", with a start pulse while busy that must be ignored.
    launch(t_ab, e_ab);
    repeat (50) @(negedge clk);
    chk("busy_mid_search", 128'(busy), 128'(1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Unreachable target exhausts all lengths up to MAX_LEN.
    lat = 2;
    t = {$urandom, $urandom, $urandom, $urandom};
    launch(t, '{found: 0, err: 0, tmo: 0, msg: '0, width: 0, count: NCAND});
    wait_done();

    // Core never answers: timeout.
    drop_mode = 1;
    launch(t_a, '{found: 0, err: 1, tmo: 1, msg: '0, width: 0, count: 1});
    wait_done();
    drop_mode = 0;

    // core_ready held low after start: no request until it rises.
    ready_low = 1;
    lat = 16;
    launch(t_a, e_a);
    repeat (10) begin
      @(negedge clk);
      #2 chk("ready_low_no_valid", 128'(msg_in_valid), 128'(0));
    end
    ready_low = 0;
    wait_done();
    chk("ready_low_single_pulse", 128'(issue_n), 128'(1));

    // Asynchronous reset while the driver waits on the core.
    launch(t_ab, e_ab);
    while (issue_n < 3 && cyc < 100000) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("busy_before_reset", 128'(busy), 128'(1));
    sb_q.delete();
    #3 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Random reachable targets against the reference search.
    for (int k = 0; k < 5; k++) begin
      lat = $urandom_range(6, 1);
      l = $urandom_range(2, 1);
      m = '0;
      for (int i = 0; i < l; i++) m[8*i +: 8] = 8'h61 + 8'($urandom_range(25));
      t = md5_of(m, l);
      e = model_search(t);
      launch(t, e);
      wait_done();
    end

    chk("scoreboard_drained", 128'(sb_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
